// File: rtl/uart_rx_byte.sv
// rtl/uart_rx_byte.sv - 8N1 UART receiver producing a byte plus one-cycle strobe
module uart_rx_byte #(
  parameter int CLKS_PER_BIT = 434,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rout,
  output logic       rout_en,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          rx_s1;
  logic          rx_s;
  logic          rx_d;

  // Two-flop synchroniser plus a delayed copy for falling-edge detection;
  // preset to 1 so reset looks like an idle line.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1 <= 1'b1;
      rx_s  <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rx_s  <= rx_s1;
      rx_d  <= rx_s;
    end
  end

  // Receive FSM: start qualification at half bit, then one sample per bit period.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      bit_idx   <= 3'd0;
      shift     <= 8'h00;
      rout      <= 8'h00;
      rout_en   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rout_en   <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          // Only a genuine 1->0 transition starts a frame, never a stuck-low line.
          if (rx_d && !rx_s) begin
            state <= ST_START;
            cnt   <= '0;
          end
        end
        ST_START: begin
          if (cnt == HALF_LAST) begin
            cnt     <= '0;
            bit_idx <= 3'd0;
            // A line already back high at mid start bit was a glitch.
            state   <= rx_s ? ST_IDLE : ST_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            shift <= {rx_s, shift[7:1]};
            if (bit_idx == 3'd7) begin
              state <= ST_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            if (rx_s) begin
              rout    <= shift;
              rout_en <= 1'b1;
              state   <= ST_IDLE;
            end else begin
              // Low stop bit: report once, then wait out any break condition.
              frame_err <= 1'b1;
              state     <= ST_BREAK;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_BREAK: begin
          if (rx_s) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign rx_busy = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_byte.sv
// tb/tb_uart_rx_byte.sv - directed and randomized bench for uart_rx_byte
module tb_uart_rx_byte;

  localparam int CPB  = 8;
  localparam int HALF = CPB / 2;
  // Cycles from the cycle rx is driven low to the cycle rout_en is observed.
  localparam int LAT  = 2 + HALF + 9 * CPB + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] rout;
  logic       rout_en;
  logic       frame_err;
  logic       rx_busy;

  uart_rx_byte #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .rout      (rout),
    .rout_en   (rout_en),
    .frame_err (frame_err),
    .rx_busy   (rx_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         strobe_cyc[$];
  logic [7:0] strobe_val[$];
  int         ferr_n   = 0;
  int         both_n   = 0;
  int         busy_run = 0;
  int         busy_max = 0;

  // Output monitor, sampled on the inactive edge.
  always @(negedge clk) begin
    if (rout_en === 1'b1) begin
      strobe_cyc.push_back(cyc);
      strobe_val.push_back(rout);
    end
    if (frame_err === 1'b1) ferr_n++;
    if (rout_en === 1'b1 && frame_err === 1'b1) both_n++;
    if (rx_busy === 1'b1) begin
      busy_run++;
      if (busy_run > busy_max) busy_max = busy_run;
    end else begin
      busy_run = 0;
    end
  end

  int passed = 0;
  int total  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] q_cyc(input int i);
    return (i < strobe_cyc.size()) ? 32'(strobe_cyc[i]) : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] q_val(input int i);
    return (i < strobe_val.size()) ? {24'h0, strobe_val[i]} : 32'hFFFF_FFFF;
  endfunction

  task automatic clear_mon();
    strobe_cyc.delete();
    strobe_val.delete();
    ferr_n = 0;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Drive one 8N1 character starting at the current negedge; t is the drive cycle.
  task automatic send(input logic [7:0] b, input logic stop_bit, output int t);
    rx = 1'b0;
    t  = cyc;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_bit;
    repeat (CPB) @(negedge clk);
  endtask

  int         t0, t1;
  logic [7:0] exp_b[$];
  int         exp_t[$];
  int         nrand;

  initial begin
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_rout", {24'h0, rout}, 32'h00);
    check("reset_rout_en", {31'h0, rout_en}, 32'h0);
    check("reset_frame_err", {31'h0, frame_err}, 32'h0);
    check("reset_rx_busy", {31'h0, rx_busy}, 32'h0);
    rst = 1'b0;
    idle(10);

    // Single character 'g'.
    clear_mon();
    send(8'h67, 1'b1, t0);
    idle(20);
    check("g_count", 32'(strobe_cyc.size()), 32'd1);
    check("g_value", q_val(0), 32'h67);
    check("g_latency", q_cyc(0) - 32'(t0), 32'(LAT));
    check("g_ferr", 32'(ferr_n), 32'd0);

    // Two characters with no idle gap.
    clear_mon();
    send(8'h30, 1'b1, t0);
    send(8'h0D, 1'b1, t1);
    idle(20);
    check("b2b_count", 32'(strobe_cyc.size()), 32'd2);
    check("b2b_val0", q_val(0), 32'h30);
    check("b2b_val1", q_val(1), 32'h0D);
    check("b2b_spacing", q_cyc(1) - q_cyc(0), 32'(10 * CPB));
    check("b2b_latency", q_cyc(0) - 32'(t0), 32'(LAT));

    // Two-cycle low glitch from idle.
    clear_mon();
    busy_max = 0;
    rx = 1'b0;
    repeat (2) @(negedge clk);
    idle(30);
    check("glitch_strobes", 32'(strobe_cyc.size()), 32'd0);
    check("glitch_ferr", 32'(ferr_n), 32'd0);
    check("glitch_busy_seen", {31'h0, busy_max > 0}, 32'd1);
    check("glitch_busy_bound", {31'h0, busy_max <= HALF + 1}, 32'd1);
    check("glitch_idle", {31'h0, rx_busy}, 32'd0);

    // Low stop bit followed by an extended break.
    clear_mon();
    send(8'hA5, 1'b0, t0);
    repeat (40) @(negedge clk);
    check("brk_ferr", 32'(ferr_n), 32'd1);
    check("brk_no_strobe", 32'(strobe_cyc.size()), 32'd0);
    check("brk_rout_held", {24'h0, rout}, 32'h0D);
    check("brk_busy", {31'h0, rx_busy}, 32'd1);
    idle(5);
    check("brk_release_idle", {31'h0, rx_busy}, 32'd0);
    check("brk_ferr_once", 32'(ferr_n), 32'd1);
    send(8'h71, 1'b1, t0);
    idle(20);
    check("post_brk_count", 32'(strobe_cyc.size()), 32'd1);
    check("post_brk_value", q_val(0), 32'h71);

    // Reset in the middle of data bit 4 of 8'hFF.
    clear_mon();
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (4 * CPB + HALF) @(negedge clk);
    check("mid_busy_before_rst", {31'h0, rx_busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_rout", {24'h0, rout}, 32'h00);
    check("mid_rst_busy", {31'h0, rx_busy}, 32'd0);
    check("mid_rst_rout_en", {31'h0, rout_en}, 32'd0);
    check("mid_rst_ferr", {31'h0, frame_err}, 32'd0);
    idle(100);
    check("mid_rst_no_strobe", 32'(strobe_cyc.size()), 32'd0);
    check("mid_rst_no_ferr", 32'(ferr_n), 32'd0);
    send(8'h55, 1'b1, t0);
    idle(20);
    check("post_rst_count", 32'(strobe_cyc.size()), 32'd1);
    check("post_rst_value", q_val(0), 32'h55);
    check("post_rst_latency", q_cyc(0) - 32'(t0), 32'(LAT));

    // Random bytes with random idle gaps, scoreboarded against sent order.
    clear_mon();
    nrand = 24;
    for (int k = 0; k < nrand; k++) begin
      logic [7:0] b;
      int         gap;
      b   = 8'($urandom_range(0, 255));
      gap = $urandom_range(0, 20);
      send(b, 1'b1, t0);
      exp_b.push_back(b);
      exp_t.push_back(t0 + LAT);
      idle(gap * CPB);
    end
    idle(3 * CPB);
    check("rand_count", 32'(strobe_cyc.size()), 32'(nrand));
    for (int k = 0; k < nrand; k++) begin
      check($sformatf("rand_val%0d", k), q_val(k), {24'h0, exp_b[k]});
      check($sformatf("rand_time%0d", k), q_cyc(k), 32'(exp_t[k]));
    end
    check("rand_ferr", 32'(ferr_n), 32'd0);
    check("never_both_strobes", 32'(both_n), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/uart_rx_byte.md
Name: uart_rx_byte

Overview:
- Serial-to-byte UART receiver that sits directly upstream of the monitor command decoder.
- Converts the asynchronous 8N1 serial line into a parallel byte `rout` plus a one-cycle `rout_en` strobe, which the decoder consumes.
- Provides metastability synchronisation, start-bit glitch rejection, mid-bit sampling, and stop-bit framing checks with break recovery.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per serial bit (50 MHz / 115200 baud); legal range >= 4.
- HALF_BIT, CLKS_PER_BIT/2 (integer floor), offset from the start edge to the start-bit sample point.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- rx  in  1  asynchronous serial input; idle level 1
- rout  out  8  last correctly framed byte
- rout_en  out  1  one-cycle strobe; `rout` is valid in the same cycle
- frame_err  out  1  one-cycle strobe when the stop bit is sampled 0
- rx_busy  out  1  high in every state except IDLE

Behaviour:
- Reset (synchronous, sampled on posedge clk while rst=1):
  - state=IDLE, rout=8'h00, rout_en=0, frame_err=0, rx_busy=0.
  - Counter and shift register cleared to 0.
  - Synchroniser flops set to 1 (line idle).
  - rst asserted mid-frame abandons the frame; no strobe is emitted.
- Synchroniser: two flops, rx -> rx_s1 -> rx_s. A third flop, rx_d, holds the previous rx_s. All FSM logic uses rx_s only.
- Bit counter: width $clog2(CLKS_PER_BIT)+1. Bit index: 3 bits.
- IDLE:
  - When rx_d=1 and rx_s=0 (falling edge), go to START and clear the counter. Call this cycle T0.
  - A level that is already 0 without a preceding 1 does not start a frame.
- START:
  - Counter increments each cycle.
  - When counter==HALF_BIT-1, sample rx_s at cycle T0+HALF_BIT.
  - If rx_s=1: glitch; return to IDLE with no strobe.
  - If rx_s=0: go to DATA, counter=0, bit index=0.
- DATA:
  - Sample when counter==CLKS_PER_BIT-1; then counter=0.
  - Data bit n is sampled at T0+HALF_BIT+(n+1)*CLKS_PER_BIT.
  - LSB first: shift = {rx_s, shift[7:1]}.
  - After bit 7, go to STOP.
- STOP:
  - Sample at T0+HALF_BIT+9*CLKS_PER_BIT.
  - If rx_s=1: on the next clock, rout<=shift, rout_en=1 for exactly one cycle, state=IDLE.
  - If rx_s=0: on the next clock, frame_err=1 for one cycle, rout is unchanged, rout_en stays 0, state=BREAK.
- BREAK: stay here until rx_s=1, then go to IDLE. Back-to-back low (break condition) yields exactly one frame_err.
- Latency: the rout_en edge occurs at T0+HALF_BIT+9*CLKS_PER_BIT+1, plus 2 cycles of synchroniser delay relative to the rx pin.
- rout holds its value between strobes.
- rout_en and frame_err are never high in the same cycle.
- Back-to-back frames:
  - The cycle after the stop sample is IDLE.
  - A start edge arriving in the stop-bit's second half is accepted. rx_d tracks continuously in all states, so an edge occurring exactly at the IDLE entry cycle is detected.
- rx_busy = (state != IDLE). It is combinational from the state register.

Test Plan:
- CLKS_PER_BIT=8. Drive 8'h67 ('g') 8N1 at 8 clk/bit -> exactly one rout_en pulse, rout=8'h67, frame_err=0, rout_en 2+4+72+1 cycles after the rx falling edge.
- Two back-to-back frames 8'h30 then 8'h0D with zero idle gap -> two rout_en pulses 80 cycles apart, rout=8'h30 then 8'h0D.
- rx low glitch of 2 cycles from idle -> returns to IDLE, no rout_en, no frame_err; rx_busy high for at most HALF_BIT+1 cycles.
- Frame 8'hA5 with stop bit driven 0, line held low 40 more cycles, then high -> one frame_err pulse, rout keeps its previous value, rx_busy stays high until the line returns to 1, then a following 8'h71 is received correctly.
- rst=1 asserted at data bit 4 of 8'hFF for 1 cycle, then the line is released high -> all outputs return to their reset values, no strobe; the next frame 8'h55 is received correctly.
- Random bytes 0x00–0xFF with idle gaps of 0–20 bits -> a scoreboard matches every byte, with zero frame_err.
